// File: rtl/pf_pkg.sv
// ============================================================================
// Module  : pf_pkg
// Purpose : Shared types and constants for the sequential binary32
//           subtractor (resta_pf_seq) and its rounding stage (pf_round).
// Contents: FSM state enum, IEEE-754 field struct, format constants.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package pf_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    SUB   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4
  } state_t;

  localparam int          BIAS      = 127;
  localparam int          EXP_MAX   = 255;
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  // Working mantissa: {carry, hidden, frac[22:0], G, R, S}
  localparam int          WORK_W    = 28;
  // Beyond this distance the smaller operand only survives as sticky
  localparam int          ALIGN_SAT = 27;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp_t;

endpackage

`default_nettype wire

// File: rtl/pf_round.sv
// ============================================================================
// Module  : pf_round
// Purpose : Combinational rounding / packing stage of resta_pf_seq.
//           Takes the normalised fraction, the G/R/S bits and the working
//           exponent, returns packed binary32 bits plus range flags.
// Macro   : RESTA_PF_RNE_EN - defined: round-to-nearest-even on G/R/S;
//                             undefined: truncation (G/R/S ignored).
// Ports   : sign     in   result sign
//           exp_in   in   signed working exponent (biased)
//           frac_in  in   23-bit fraction below the hidden bit
//           grs      in   {guard, round, sticky}
//           bits     out  packed {sign, exp[7:0], frac}
//           ovf      out  rounded exponent >= 255
//           unf      out  rounded exponent <= 0
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module pf_round
  import pf_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp_in,
  input  logic [22:0]       frac_in,
  input  logic [2:0]        grs,
  output logic [31:0]       bits,
  output logic              ovf,
  output logic              unf
);

  logic [22:0]       frac_r;
  logic signed [9:0] exp_r;

`ifdef RESTA_PF_RNE_EN
  logic        rnd_up;
  logic [23:0] sum;

  always_comb begin
    rnd_up = grs[2] & (grs[1] | grs[0] | frac_in[0]);
    sum    = {1'b0, frac_in} + {23'd0, rnd_up};
    // A carry out of the fraction means it was all ones: the fraction wraps
    // to zero and the value becomes the next power of two.
    frac_r = sum[22:0];
    exp_r  = exp_in + (sum[23] ? 10'sd1 : 10'sd0);
  end
`else
  logic unused_grs;

  assign unused_grs = ^grs;

  always_comb begin
    frac_r = frac_in;
    exp_r  = exp_in;
  end
`endif

  always_comb begin
    ovf  = (exp_r >= $signed(10'(EXP_MAX)));
    unf  = (exp_r <= 10'sd0);
    bits = {sign, exp_r[7:0], frac_r};
  end

endmodule

`default_nettype wire

// File: rtl/resta_pf_seq.sv
// ============================================================================
// Module  : resta_pf_seq
// Purpose : Multi-cycle binary32 subtractor, result = A - B, start/done
//           handshake. Bit-serial alignment and normalisation shifters.
// Macro   : RESTA_PF_RNE_EN (round-to-nearest-even vs truncation, pf_round)
// Ports   : clk     in   clock, rising edge
//           rst     in   asynchronous active-high reset
//           start   in   request, sampled only in IDLE
//           A, B    in   operands, sampled with start
//           busy    out  high in every state except IDLE
//           done    out  one-cycle completion pulse
//           result  out  A - B, held until the next accepted start
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module resta_pf_seq
  import pf_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [WORK_W-1:0]   x_q, x_d;
  logic [WORK_W-1:0]   y_q, y_d;
  logic signed [9:0]   exp_q, exp_d;
  logic                sign_q, sign_d;
  logic                eff_sub_q, eff_sub_d;
  logic                nan_q, nan_d;
  logic                zero_q, zero_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [31:0]         result_q, result_d;

  // Operand preparation (used only when a start is accepted)
  fp_t         a_op, b_op;
  logic        b_sign, swap, special;
  logic [23:0] a_man, b_man, big_man, small_man;
  logic [7:0]  big_exp, small_exp, exp_diff;
  logic [4:0]  d_sat;

  always_comb begin
    a_op      = fp_t'(A);
    b_op      = fp_t'(B);
    b_sign    = ~b_op.sign;
    // Denormals flush to signed zero: hidden bit and fraction cleared
    a_man     = (a_op.exp == 8'd0) ? 24'd0 : {1'b1, a_op.frac};
    b_man     = (b_op.exp == 8'd0) ? 24'd0 : {1'b1, b_op.frac};
    special   = (a_op.exp == 8'(EXP_MAX)) || (b_op.exp == 8'(EXP_MAX));
    swap      = {b_op.exp, b_man} > {a_op.exp, a_man};
    big_exp   = swap ? b_op.exp : a_op.exp;
    small_exp = swap ? a_op.exp : b_op.exp;
    big_man   = swap ? b_man : a_man;
    small_man = swap ? a_man : b_man;
    exp_diff  = big_exp - small_exp;
    d_sat     = (exp_diff > 8'(ALIGN_SAT)) ? 5'(ALIGN_SAT) : exp_diff[4:0];
  end

  logic [31:0] rnd_bits;
  logic        rnd_ovf, rnd_unf;

  pf_round u_round (
    .sign    (sign_q),
    .exp_in  (exp_q),
    .frac_in (x_q[25:3]),
    .grs     (x_q[2:0]),
    .bits    (rnd_bits),
    .ovf     (rnd_ovf),
    .unf     (rnd_unf)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    eff_sub_d = eff_sub_q;
    nan_d     = nan_q;
    zero_d    = zero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d    = 1'b1;
          nan_d     = special;
          zero_d    = 1'b0;
          sign_d    = swap ? b_sign : a_op.sign;
          eff_sub_d = a_op.sign ^ b_sign;
          x_d       = {1'b0, big_man, 3'b000};
          y_d       = {1'b0, small_man, 3'b000};
          exp_d     = $signed({2'b00, big_exp});
          // Specials skip the datapath; the extra ROUND cycle keeps their
          // latency at two edges.
          cnt_d     = special ? 5'd1 : d_sat;
          state_d   = special ? ROUND : ALIGN;
        end
      end

      ALIGN: begin
        if (cnt_q != 5'd0) begin
          y_d   = {1'b0, y_q[WORK_W-1:2], y_q[1] | y_q[0]};
          cnt_d = cnt_q - 5'd1;
        end else begin
          state_d = SUB;
        end
      end

      SUB: begin
        // X >= Y in magnitude, so the subtraction never goes negative
        x_d     = eff_sub_q ? (x_q - y_q) : (x_q + y_q);
        state_d = NORM;
      end

      NORM: begin
        if (x_q[WORK_W-1]) begin
          x_d     = {1'b0, x_q[WORK_W-1:2], x_q[1] | x_q[0]};
          exp_d   = exp_q + 10'sd1;
          state_d = ROUND;
        end else if (x_q == '0) begin
          zero_d  = 1'b1;
          state_d = ROUND;
        end else if (x_q[WORK_W-2]) begin
          state_d = ROUND;
        end else begin
          x_d   = {x_q[WORK_W-2:0], 1'b0};
          exp_d = exp_q - 10'sd1;
        end
      end

      ROUND: begin
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (nan_q)        result_d = QNAN;
          else if (zero_q)  result_d = 32'h0000_0000;
          else if (rnd_ovf) result_d = {sign_q, 8'hFF, 23'd0};
          else if (rnd_unf) result_d = {sign_q, 31'd0};
          else              result_d = rnd_bits;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      x_q       <= '0;
      y_q       <= '0;
      exp_q     <= 10'sd0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      nan_q     <= 1'b0;
      zero_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      exp_q     <= exp_d;
      sign_q    <= sign_d;
      eff_sub_q <= eff_sub_d;
      nan_q     <= nan_d;
      zero_q    <= zero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_resta_pf_seq.sv
// ============================================================================
// Module  : tb_resta_pf_seq
// Purpose : Self-checking bench for resta_pf_seq. Stimulus pushes expected
//           {result, latency} into a scoreboard; a monitor pops on done.
//           Expected values come from constants or from an exact-integer
//           reference model of A - B with the configured rounding.
// Macro   : RESTA_PF_RNE_EN selects the model's rounding mode.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_resta_pf_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] result;

  always #5 clk = ~clk;

  resta_pf_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          k;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc         = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   busy_cnt    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Exact reference: significands as integers, exact sum/difference,
  // then a generic round to 24 significant bits.
  function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b,
                                          output int lat);
    logic            sa, sbn, sx, sy;
    int              ea, eb, ex, ey, d, dd, p, n, e_res, sh;
    longint unsigned ma, mb, mx, my, v, q;
`ifdef RESTA_PF_RNE_EN
    longint unsigned rem, half;
`endif
    sa  = a[31];
    sbn = ~b[31];
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    lat = 2;
    if (ea == 255 || eb == 255) return 32'h7FC0_0000;
    ma = (ea == 0) ? 64'd0 : {40'd0, 1'b1, a[22:0]};
    mb = (eb == 0) ? 64'd0 : {40'd0, 1'b1, b[22:0]};
    if (eb > ea || (eb == ea && mb > ma)) begin
      sx = sbn; ex = eb; mx = mb; sy = sa;  ey = ea; my = ma;
    end else begin
      sx = sa;  ex = ea; mx = ma; sy = sbn; ey = eb; my = mb;
    end
    d   = ex - ey;
    lat = 4 + ((d > 27) ? 27 : d);
    if (mx == 0) return 32'h0000_0000;
    if (my == 0) begin
      v  = mx;
      dd = 0;
    end else begin
      // Far below the rounding point any nonzero remainder rounds alike
      if (d > 38) begin dd = 38; my = 64'd1; end
      else dd = d;
      v = (sx != sy) ? ((mx << dd) - my) : ((mx << dd) + my);
    end
    if (v == 0) return 32'h0000_0000;
    p = 0;
    for (int i = 0; i < 64; i++) if (v[i]) p = i;
    n = 23 + dd - p;
    if (n > 0) lat += n;
    e_res = ex - dd + p - 23;
    if (p > 23) begin
      sh = p - 23;
      q  = v >> sh;
`ifdef RESTA_PF_RNE_EN
      rem  = v & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin q = q >> 1; e_res++; end
`endif
    end else begin
      q = v << (23 - p);
    end
    if (e_res >= 255) return {sx, 8'hFF, 23'd0};
    if (e_res <= 0)   return {sx, 31'd0};
    return {sx, e_res[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_a();
    logic [31:0] a;
    a = $urandom;
    case ($urandom_range(0, 19))
      0:       a[30:23] = 8'd0;
      1:       a[30:23] = 8'hFF;
      2, 3:    a[30:23] = 8'(250 + $urandom_range(0, 4));
      4, 5:    a[30:23] = 8'(1 + $urandom_range(0, 3));
      default: a[30:23] = 8'(100 + $urandom_range(0, 50));
    endcase
    return a;
  endfunction

  function automatic logic [31:0] rnd_partner(input logic [31:0] a);
    logic [31:0] b;
    int          e;
    b = $urandom;
    case ($urandom_range(0, 11))
      0, 1, 2, 3: begin
        e = int'(a[30:23]) + int'($urandom_range(0, 6)) - 3;
        if (e < 1)   e = 1;
        if (e > 254) e = 254;
        b[30:23] = e[7:0];
      end
      4, 5: begin
        b     = a ^ {28'd0, 4'($urandom_range(0, 15))};
        b[31] = 1'($urandom_range(0, 1));
      end
      6:       b[30:23] = 8'd0;
      7:       b[30:23] = 8'hFF;
      8: begin
        e = int'(a[30:23]) - 20 - int'($urandom_range(0, 20));
        if (e < 1) e = 1;
        b[30:23] = e[7:0];
      end
      default: ;
    endcase
    return b;
  endfunction

  // Waits until every pushed expectation has been retired by the monitor
  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input int el);
    exp_t e;
    start = 1'b1;
    A     = a;
    B     = b;
    e.res = er;
    e.lat = el;
    e.k   = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    wait_idle();
  endtask

  task automatic issue_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    int          el;
    er = ref_sub(a, b, el);
    issue(a, b, er, el);
  endtask

  // Monitor: retires one expectation per done pulse
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        busy_cnt = 0;
      end else if (done) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done result=%h required=no_done", result);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", result, mon_e.res);
          check("latency", 32'(cyc - mon_e.k), 32'(mon_e.lat));
          check("busy_at_done", {31'd0, busy}, 32'd0);
          check("busy_cycles", 32'(busy_cnt), 32'(mon_e.lat));
        end
        busy_cnt = 0;
      end else if (busy) begin
        busy_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_expired cycle=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'd0, busy}, 32'd0);
    check("reset_done",   {31'd0, done}, 32'd0);
    check("reset_result", result,        32'h0000_0000);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors with hand-derived results and latencies
    issue(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4);
    issue(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 5);
    issue(32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 5);
    issue(32'h3FC0_0000, 32'h3FA0_0000, 32'h3E80_0000, 6);
    issue(32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 4);
`ifdef RESTA_PF_RNE_EN
    issue(32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000, 32);
`else
    issue(32'h3F80_0000, 32'h3080_0000, 32'h3F7F_FFFF, 32);
`endif
    issue(32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 2);
    issue(32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 4);
    issue(32'h0040_0000, 32'h0000_0001, 32'h0000_0000, 4);
    issue(32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 4);
    issue(32'h0080_0000, 32'h0040_0000, 32'h0080_0000, 5);
    issue(32'h00C0_0000, 32'h0080_0000, 32'h0000_0000, 5);
    issue(32'h0080_0001, 32'h0080_0000, 32'h0000_0000, 27);

    // Start held high: second op accepted in the done cycle, rest ignored
    begin
      exp_t e1, e2;
      start  = 1'b1;
      A      = 32'h4040_0000;
      B      = 32'h3F80_0000;
      e1.res = 32'h4000_0000; e1.lat = 5; e1.k = cyc + 1;
      e2.res = 32'h4000_0000; e2.lat = 5; e2.k = cyc + 7;
      exp_q.push_back(e1);
      exp_q.push_back(e2);
      repeat (10) @(negedge clk);
      start = 1'b0;
      wait_idle();
    end

    // Reset three cycles into a long operation
    start = 1'b1;
    A     = 32'h3F80_0000;
    B     = 32'h3080_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy",   {31'd0, busy}, 32'd0);
    check("midrst_done",   {31'd0, done}, 32'd0);
    check("midrst_result", result,        32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("no_busy_after_rst", {31'd0, busy}, 32'd0);

    // Randomized operands against the reference model
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      a = rnd_a();
      b = rnd_partner(a);
      issue_model(a, b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
